// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply path).
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } muldiv_state_t;

  // SPECIAL-opcode funct fields handled by this unit.
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on unsigned magnitudes.
// Multiply: {acc,shr} holds partial product / remaining multiplier bits,
//   operand is the multiplicand.
// Divide: acc holds the partial remainder, shr the dividend bits shifting
//   out and quotient bits shifting in, operand is the divisor.
// Optional feature macro: MULDIV_FAST_MUL_EN (handled in the sequencer).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] shr,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] shr_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Single shift-add or restore-subtract step.
  always_comb begin
    // NOTE: every output gets a value on every path first, so no latch is inferred.
    acc_next = acc;
    shr_next = shr;
    sum      = acc + (shr[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted  = {acc[WIDTH-1:0], shr[WIDTH-1]};
    trial    = shifted - {1'b0, operand};
    if (is_div) begin
      // The partial remainder stays below 2*divisor, so the top bit of the
      // trial difference is a valid sign.
      if (!trial[WIDTH]) begin
        acc_next = trial;
        shr_next = {shr[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted;
        shr_next = {shr[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {1'b0, sum[WIDTH:1]};
      shr_next = {sum[0], shr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// FSM IDLE -> PREP -> ITER (ITER steps) -> FIX -> IDLE; done pulses the cycle
// after FIX with the committed HI/LO. Decode is stalled while a HI/LO user
// waits behind an operation in flight.
// Optional feature macro: MULDIV_FAST_MUL_EN -- mult/multu use a single-cycle
// product and go PREP -> FIX directly; divide is unchanged.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             mtE,
  input  logic             mthiE,
  input  logic             hiloD,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stallD
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_PREP = ST_PREP;
  localparam logic [1:0] S_ITER = ST_ITER;
  localparam logic [1:0] S_FIX  = ST_FIX;

  logic [1:0]         state;
  muldiv_op_t         op_q;
  logic [WIDTH-1:0]   opa;       // raw operand until PREP, magnitude after
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   shr;
  logic [CNT_W-1:0]   cnt;
  logic               sign_q;    // product / quotient sign
  logic               sign_r;    // remainder sign (follows dividend)

  logic               is_div;
  logic               is_signed;
  logic               fast_mul;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   step_operand;
  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   shr_next;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign is_div       = op_is_div(op_q);
  assign is_signed    = op_is_signed(op_q);
  assign abs_a        = (is_signed && opa[WIDTH-1]) ? -opa : opa;
  assign abs_b        = (is_signed && opb[WIDTH-1]) ? -opb : opb;
  assign step_operand = is_div ? opb : opa;

  assign busy   = (state != S_IDLE);
  assign stallD = hiloD & (busy | startE);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = !is_div;
  assign prod_mag = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
`else
  assign fast_mul = 1'b0;
  assign prod_mag = {acc[WIDTH-1:0], shr};
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .shr      (shr),
    .operand  (step_operand),
    .acc_next (acc_next),
    .shr_next (shr_next)
  );

  // Sign fixup and result selection used in FIX; divide by zero forces LO
  // to all ones while HI keeps the signed dividend.
  always_comb begin
    prod   = sign_q ? -prod_mag : prod_mag;
    rem    = sign_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    quo    = (opb == '0) ? '1 : (sign_q ? -shr : shr);
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  // FSM, iteration counter, operand latches and HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      op_q   <= MULT;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      shr    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      done <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (startE) begin
              op_q  <= muldiv_op_t'(opE);
              opa   <= srcaE;
              opb   <= srcbE;
              state <= S_PREP;
            end else if (mtE) begin
              if (mthiE) hi <= srcaE;
              else       lo <= srcaE;
            end
          end
          S_PREP: begin
            opa    <= abs_a;
            opb    <= abs_b;
            acc    <= '0;
            shr    <= is_div ? abs_a : abs_b;
            cnt    <= CNT_W'(ITER - 1);
            sign_q <= is_signed & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            sign_r <= is_signed & is_div & opa[WIDTH-1];
            state  <= fast_mul ? S_FIX : S_ITER;
          end
          S_ITER: begin
            acc <= acc_next;
            shr <= shr_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= S_FIX;
          end
          S_FIX: begin
            hi    <= fix_hi;
            lo    <= fix_lo;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: an arithmetic reference model
// (64-bit products, truncating division, countdown latency) compared against
// the DUT every cycle, plus directed vectors with hand-computed HI/LO.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        startE = 1'b0;
  logic [1:0]  opE    = 2'b00;
  logic [31:0] srcaE  = '0;
  logic [31:0] srcbE  = '0;
  logic        mtE    = 1'b0;
  logic        mthiE  = 1'b0;
  logic        hiloD  = 1'b0;
  logic        abort  = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stallD;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .startE (startE),
    .opE    (opE),
    .srcaE  (srcaE),
    .srcbE  (srcbE),
    .mtE    (mtE),
    .mthiE  (mthiE),
    .hiloD  (hiloD),
    .abort  (abort),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done),
    .stallD (stallD)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Cycles busy stays high after the start edge.
  function automatic int model_latency(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) return 2;
`endif
    return 34;
  endfunction

  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_pend = '0;
  int          m_rem  = 0;
  logic        m_done = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (abort) m_rem = 0;
        else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi   = m_pend[63:32];
            m_lo   = m_pend[31:0];
            m_done = 1'b1;
          end
        end
      end else if (!abort) begin
        if (startE) begin
          m_pend = model_result(opE, srcaE, srcbE);
          m_rem  = model_latency(opE);
        end else if (mtE) begin
          if (mthiE) m_hi = srcaE;
          else       m_lo = srcaE;
        end
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    check("cyc_busy",   {63'h0, busy},   {63'h0, (m_rem != 0)});
    check("cyc_done",   {63'h0, done},   {63'h0, m_done});
    check("cyc_stallD", {63'h0, stallD}, {63'h0, hiloD & ((m_rem != 0) | startE)});
    check("cyc_hi",     {32'h0, hi},     {32'h0, m_hi});
    check("cyc_lo",     {32'h0, lo},     {32'h0, m_lo});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [13] = '{
    '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB}, // mult -3*7
    '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E}, // divu 100/7
    '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD}, // div -7/2
    '{2'b10, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF}, // div 5/0
    '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000}, // overflow
    '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001}, // multu max
    '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}, // mult min*min
    '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF}, // div -5/0
    '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF}, // divu
    '{2'b00, 32'd6,         32'd7,         32'h0000_0000, 32'h0000_002A}, // mult 6*7
    '{2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000}, // mult -1*min
    '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD}, // div 7/-2
    '{2'b01, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000}  // multu
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx);
    int cycles;
    opE    = vecs[idx].op;
    srcaE  = vecs[idx].a;
    srcbE  = vecs[idx].b;
    startE = 1'b1;
    tick();
    startE = 1'b0;
    srcaE  = 32'hDEAD_BEEF;
    srcbE  = 32'h0BAD_F00D;
    cycles = 1;
    while (!done && cycles < 100) begin
      tick();
      cycles++;
    end
    check($sformatf("v%0d_latency", idx), 64'(cycles), 64'(model_latency(vecs[idx].op) + 1));
    check($sformatf("v%0d_hi", idx), {32'h0, hi}, {32'h0, vecs[idx].hi});
    check($sformatf("v%0d_lo", idx), {32'h0, lo}, {32'h0, vecs[idx].lo});
    check($sformatf("v%0d_busy_low", idx), {63'h0, busy}, 64'h0);
    tick();
    check($sformatf("v%0d_done_one_cycle", idx), {63'h0, done}, 64'h0);
  endtask

  initial begin
    int pulses;
    hiloD = 1'b1;
    repeat (3) tick();
    // Reset state: registers clear and stallD stays low with nothing in flight.
    check("rst_hi",     {32'h0, hi},     64'h0);
    check("rst_lo",     {32'h0, lo},     64'h0);
    check("rst_busy",   {63'h0, busy},   64'h0);
    check("rst_done",   {63'h0, done},   64'h0);
    check("rst_stallD", {63'h0, stallD}, 64'h0);
    hiloD = 1'b0;
    reset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_vec(i);

    // mflo waiting in D from the start cycle: stall cycles 0..34, release at 35.
    opE = 2'b11; srcaE = 32'd100; srcbE = 32'd7;
    startE = 1'b1;
    hiloD  = 1'b1;
    #1;
    check("stall_c0", {63'h0, stallD}, 64'h1);
    tick();
    startE = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      #1;
      check($sformatf("stall_c%0d", c), {63'h0, stallD}, {63'h0, (c <= 34)});
      if (c < 35) tick();
    end
    check("stall_mflo_lo", {32'h0, lo}, 64'h0000_000E);
    hiloD = 1'b0;
    tick();

    // mthi / mtlo then abort a multiply mid-iteration.
    mtE = 1'b1; mthiE = 1'b1; srcaE = 32'h1234_5678;
    tick();
    mtE = 1'b0;
    check("mthi_hi", {32'h0, hi}, 64'h1234_5678);
    mtE = 1'b1; mthiE = 1'b0; srcaE = 32'hCAFE_F00D;
    tick();
    mtE = 1'b0;
    check("mtlo_lo", {32'h0, lo}, 64'hCAFE_F00D);
    opE = 2'b00; srcaE = 32'd3; srcbE = 32'd5; startE = 1'b1;
    tick();
    startE = 1'b0;
    repeat (5) tick();
    check("abort_busy_before", {63'h0, busy}, 64'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy_after", {63'h0, busy}, 64'h0);
    check("abort_hi_kept",    {32'h0, hi},   64'h1234_5678);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) pulses++;
      tick();
    end
    check("abort_no_done", 64'(pulses), 64'h0);
    check("abort_lo_kept", {32'h0, lo}, 64'hCAFE_F00D);

    // abort together with startE in IDLE: the start is dropped.
    startE = 1'b1; abort = 1'b1;
    tick();
    startE = 1'b0; abort = 1'b0;
    check("abort_start_ignored", {63'h0, busy}, 64'h0);

    // Reset in the middle of a divide clears everything immediately.
    opE = 2'b10; srcaE = 32'h0001_2345; srcbE = 32'd3; startE = 1'b1;
    tick();
    startE = 1'b0;
    repeat (9) tick();
    check("midrst_busy_before", {63'h0, busy}, 64'h1);
    reset = 1'b0;
    #1;
    check("midrst_hi",   {32'h0, hi},   64'h0);
    check("midrst_lo",   {32'h0, lo},   64'h0);
    check("midrst_busy", {63'h0, busy}, 64'h0);
    check("midrst_done", {63'h0, done}, 64'h0);
    tick();
    tick();
    reset = 1'b1;
    repeat (40) tick();
    check("midrst_no_commit_lo", {32'h0, lo}, 64'h0);
    check("midrst_no_commit_hi", {32'h0, hi}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle multiply/divide unit and HI/LO register controller for the MIPS pipeline. It accepts mult/multu/div/divu and mthi/mtlo from the Execute stage and runs an iterative 32-step shift-add or restoring-divide datapath. It owns the HI and LO registers and raises a Decode-stage stall while an operation is in flight and a HI/LO-touching instruction is waiting. Its HI/LO outputs feed the writeback mux selected by the controller's move_MU path (mfhi/mflo).

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width
- ITER, WIDTH, iteration steps per operation

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- startE  in  1  mult/div instruction in E; sampled at clk rising edge
- opE  in  2  00 mult, 01 multu, 10 div, 11 divu
- srcaE  in  WIDTH  rs operand (dividend / multiplicand / mt source)
- srcbE  in  WIDTH  rt operand (divisor / multiplier)
- mtE  in  1  mthi/mtlo in E
- mthiE  in  1  with mtE: 1 = write HI, 0 = write LO
- hiloD  in  1  any mult/div/mt/mf instruction in Decode
- abort  in  1  cancel in-flight operation (exception/flush)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO committed by an operation
- stallD  out  1  stall Decode and Fetch

## Operation
- FSM states: IDLE, PREP, ITER, FIX.
- IDLE: startE=1 -> latch operands and op, go PREP. mtE=1 -> write srcaE to HI or LO at the edge; stay IDLE.
- PREP (1 cycle): signed ops take absolute values and record result sign (mult: sa^sb; div quotient: sa^sb, remainder: sa); clear accumulator; counter = ITER-1.
- ITER: one shift-add (mul) or restore-subtract (div) step per cycle; counter decrements; at 0 go FIX.
- FIX (1 cycle): apply signs (two's complement negate), write HI/LO, pulse done, go IDLE.
- Results: mult → {HI,LO} = 64-bit product. div → LO = quotient, HI = remainder; remainder sign follows dividend.
- Divide by zero: no trap; LO = all ones, HI = |dividend| with dividend sign restored. Iteration count unchanged.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- busy = state != IDLE.
- stallD = hiloD & (busy | startE). startE term covers the cycle before busy rises.
- startE or mtE while busy: ignored (illegal; stallD prevents it).
- abort: any state → IDLE next edge, HI/LO unchanged, no done. abort with startE in IDLE: start ignored.
- startE and mtE together: illegal; startE wins.

## Timing
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, stallD=0 (stallD combinational, follows hiloD).
- startE high in cycle 0 → PREP cycle 1, ITER cycles 2..33, FIX cycle 34. done=1 and new HI/LO visible in cycle 35 (registered). busy high cycles 1..34.
- mt write visible on hi/lo the cycle after mtE.
- mfhi held in D by stallD proceeds in the cycle busy falls and reads committed values via hi/lo at its E stage.
- Reset asserted mid-operation: immediate return to reset values; no partial commit.

## Configuration
- MULDIV_FAST_MUL_EN defined: mult/multu use a single-cycle combinational product. PREP→FIX directly, skipping ITER; results visible in cycle 3; busy high cycles 1..2. Divide is unchanged.
- Undefined: all operations are iterative as above.

## Structure
- Shared package muldiv_pkg: muldiv_op_t enum (MULT, MULTU, DIV, DIVU), muldiv_state_t enum, funct constants (F_MFHI 6'b010000, F_MTHI 6'b010001, F_MFLO 6'b010010, F_MTLO 6'b010011, F_MULT 6'b011000..F_DIVU 6'b011011).
- One sub-module, muldiv_step: combinational single-iteration shift-add / restore-subtract. The sequencer holds the FSM, counter, sign fixup and HI/LO registers.

## Test plan
- mult -3 × 7 → at cycle 35: HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulse one cycle, busy low.
- divu 100 / 7 → LO=0x0000000E, HI=0x00000002. div -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div 5 / 0 → LO=0xFFFFFFFF, HI=0x00000005; 0x80000000 / -1 → LO=0x80000000, HI=0.
- startE cycle 0 with hiloD=1 (mflo) cycles 0..35 → stallD=1 cycles 0..34, 0 in cycle 35. mflo then reads the new LO.
- mthi 0x12345678 then abort during an ITER of mult → HI stays 0x12345678, no done, busy low next cycle.
- reset low at cycle 10 of a divide → hi=lo=0, busy=0 immediately. With MULDIV_FAST_MUL_EN, mult 6×7 → LO=42 at cycle 3.
